// File: rtl/imem_fetch.sv
// imem_fetch: instruction-memory responder for the single-cycle CPU.
// Accepts a fetch request for the byte address on pc, waits a fixed number
// of cycles, then returns the addressed word with a one-cycle valid strobe.
// That strobe doubles as the PC write enable. Misaligned or out-of-range
// fetches return a NOP and set a sticky fault flag. A side load port writes
// the store in any state.
module imem_fetch #(
    parameter int ADDR_W      = 6,   // word-address width, store holds 2^ADDR_W words
    parameter int WAIT_STATES = 2    // extra read cycles per fetch, 0..15
) (
    input  logic                clk,
    input  logic                Reset,      // asynchronous, active-low
    input  logic [31:0]         pc,
    input  logic                fetchReq,
    output logic [31:0]         instr,
    output logic                instrValid,
    output logic                PCWre,
    output logic                busy,
    output logic                fault,
    input  logic                loadWe,
    input  logic [ADDR_W-1:0]   loadAddr,
    input  logic [31:0]         loadData
);

    localparam int          DEPTH  = 1 << ADDR_W;
    localparam logic [3:0]  WS_CNT = 4'(WAIT_STATES);
    localparam logic [31:0] NOP    = 32'h0000_0000;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_reg;
    logic [3:0]        cnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              bad_reg;
    logic [31:0]       instr_reg;
    logic              fault_reg;
    logic              req_bad;

    // Instruction store; deliberately not reset, contents come from the load port.
    logic [31:0] mem [DEPTH];

    // A request is bad when the byte address is not word aligned or
    // points past the end of the store.
    assign req_bad = (pc[1:0] != 2'b00) || (pc[31:ADDR_W+2] != '0);

    // Load port: synchronous write, active in every FSM state.
    always_ff @(posedge clk) begin
        if (loadWe) begin
            mem[loadAddr] <= loadData;
        end
    end

    // Fetch FSM: accept in IDLE, count wait states, capture the word on the
    // WAIT-exit edge (reads the pre-write value if a load hits the same edge),
    // strobe for one cycle in DONE.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
            addr_reg  <= '0;
            bad_reg   <= 1'b0;
            instr_reg <= NOP;
            fault_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (fetchReq) begin
                        addr_reg  <= pc[ADDR_W+1:2];
                        bad_reg   <= req_bad;
                        cnt_reg   <= WS_CNT;
                        state_reg <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        if (bad_reg) begin
                            instr_reg <= NOP;
                            fault_reg <= 1'b1;
                        end else begin
                            instr_reg <= mem[addr_reg];
                        end
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    // fetchReq is ignored here; it is picked up in the next IDLE cycle.
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode straight from the state register.
    always_comb begin
        instr      = instr_reg;
        fault      = fault_reg;
        instrValid = (state_reg == S_DONE);
        PCWre      = (state_reg == S_DONE);
        busy       = (state_reg != S_IDLE);
    end

endmodule
